// File: rtl/calc_sequencer.sv
// calc_sequencer: walks an operand block in SRAM through the external datapath,
// one outstanding read at a time, and writes the final datapath result back.
module calc_sequencer #(
    parameter int                ADDR_W   = 11,
    parameter int                DATA_W   = 32,
    parameter int                CNT_W    = 10,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 11'h62C
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_calc,
    input  logic              abort,
    input  logic [ADDR_W-1:0] op_base,
    input  logic [CNT_W-1:0]  op_count,
    input  logic [ADDR_W-1:0] result_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_grant,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dp_clear,
    output logic              dp_load,
    output logic [DATA_W-1:0] dp_operand,
    input  logic [DATA_W-1:0] dp_result,
    output logic              busy,
    output logic              done_calc,
    output logic              err,
    output logic [DATA_W-1:0] result_output
);
    typedef enum logic [3:0] {IDLE, CHECK, CLEAR, RD_REQ, RD_WAIT, LOAD, SETTLE, WB_REQ, DONE, ERR} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, raddr_q, raddr_d, ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, rem_q, rem_d;
    logic [DATA_W-1:0] opnd_q, opnd_d, wdata_q, wdata_d, result_q, result_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   end_addr;
    logic              bad;

    // end address is one bit wider so an oversized block cannot wrap into range
    assign end_addr = {1'b0, base_q} + (ADDR_W+1)'(count_q);
    assign bad = count_q == '0 || base_q == '0 || end_addr > {1'b0, MAX_ADDR} ||
                 raddr_q == '0 || raddr_q >= MAX_ADDR;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_calc) state_d = CHECK;
            CHECK:   state_d = bad ? ERR : CLEAR;
            CLEAR:   state_d = RD_REQ;
            RD_REQ:  if (mem_grant) state_d = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_d = LOAD;
            LOAD:    state_d = rem_q == CNT_W'(1) ? SETTLE : RD_REQ;
            SETTLE:  state_d = WB_REQ;
            WB_REQ:  if (mem_grant) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_comb begin
        mem_rd        = state_q == RD_REQ;
        mem_wr        = state_q == WB_REQ;
        mem_addr      = mem_rd ? ptr_q : mem_wr ? raddr_q : '0;
        mem_wdata     = wdata_q;
        dp_clear      = state_q == CLEAR;
        dp_load       = state_q == LOAD;
        dp_operand    = opnd_q;
        busy          = state_q != IDLE;
        done_calc     = state_q == DONE || state_q == ERR;
        err           = err_q;
        result_output = result_q;
    end

    // data updates keyed on state_d so an abort suppresses capture and write-back
    always_comb begin
        base_d   = base_q;
        count_d  = count_q;
        raddr_d  = raddr_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        err_d    = err_q;
        if (state_q == IDLE && start_calc) begin
            base_d  = op_base;
            count_d = op_count;
            raddr_d = result_addr;
            err_d   = 1'b0;
        end
        if (state_q == CLEAR) begin
            ptr_d = base_q;
            rem_d = count_q;
        end
        if (state_q == LOAD) begin
            ptr_d = ptr_q + ADDR_W'(1);
            rem_d = rem_q - CNT_W'(1);
        end
        if (state_d == ERR) err_d = 1'b1;
        if (state_d == LOAD) opnd_d = mem_rdata;
        if (state_d == WB_REQ) wdata_d = dp_result;
        if (state_d == DONE) result_d = wdata_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            base_q   <= '0;
            count_q  <= '0;
            raddr_q  <= '0;
            ptr_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            count_q  <= count_d;
            raddr_q  <= raddr_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end
endmodule
